// File: rtl/gray_pkg.sv
// Shared types for the command issue queue feeding the gray-coded control FSM.
package gray_pkg;

    localparam int RPT_W_DEF = 3;

    typedef logic [3:0] cmd_t;

    localparam cmd_t IDLE_CMD_DEF = 4'b0000;

    typedef struct packed {
        cmd_t                 cmd;
        logic [RPT_W_DEF-1:0] rpt;
    } entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } issue_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a level counter.
// The head is read combinationally so the issuer can load it on the pop edge.
module sync_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_reg == LVL_W'(DEPTH));
    assign empty   = (level_reg == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr_reg];
    assign level   = level_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/cmd_issue_queue.sv
// Buffers (cmd, repeat) entries and drives a registered cmd bus, holding each
// command for rpt+1 cycles and falling back to IDLE_CMD when nothing is queued.
module cmd_issue_queue
    import gray_pkg::*;
#(
    parameter int         DEPTH    = 8,
    parameter int         RPT_W    = RPT_W_DEF,
    parameter logic [3:0] IDLE_CMD = IDLE_CMD_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [3:0]                   in_cmd,
    input  logic [RPT_W-1:0]             in_rpt,
    output logic                         in_ready,
    input  logic                         flush,
    output logic [3:0]                   cmd,
    output logic                         cmd_active,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int ENTRY_W = 4 + RPT_W;

    logic               ready_en_reg;
    issue_state_t       state_reg, state_next;
    logic [RPT_W-1:0]   hcnt_reg, hcnt_next;
    cmd_t               cmd_reg, cmd_next;
    logic               active_reg, active_next;

    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] head;
    logic               push;
    logic               pop;

    // Low only while in reset and for the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
        end
    end

    assign in_ready = !fifo_full && !flush && ready_en_reg;
    assign push     = in_valid && in_ready;
    assign pop      = !flush && !fifo_empty && ((state_reg == IDLE) || (hcnt_reg == '0));

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata ({in_cmd, in_rpt}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    always_comb begin
        state_next  = state_reg;
        hcnt_next   = hcnt_reg;
        cmd_next    = cmd_reg;
        active_next = active_reg;
        if (flush) begin
            state_next  = IDLE;
            hcnt_next   = '0;
            cmd_next    = IDLE_CMD;
            active_next = 1'b0;
        end else if (pop) begin
            state_next  = HOLD;
            hcnt_next   = head[RPT_W-1:0];
            cmd_next    = head[ENTRY_W-1 -: 4];
            active_next = 1'b1;
        end else if ((state_reg == HOLD) && (hcnt_reg != '0)) begin
            hcnt_next = hcnt_reg - 1'b1;
        end else begin
            // Last hold cycle with nothing queued, or idle with an empty FIFO.
            state_next  = IDLE;
            cmd_next    = IDLE_CMD;
            active_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            hcnt_reg   <= '0;
            cmd_reg    <= IDLE_CMD;
            active_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            hcnt_reg   <= hcnt_next;
            cmd_reg    <= cmd_next;
            active_reg <= active_next;
        end
    end

    assign cmd        = cmd_reg;
    assign cmd_active = active_reg;

endmodule

// File: tb/tb_cmd_issue_queue.sv
// Scoreboard bench: stimulus queues expected active-cycle commands, a negedge
// monitor pops and compares them; directed checks cover timing and level.
module tb_cmd_issue_queue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_cmd;
    logic [2:0] in_rpt;
    logic       in_ready;
    logic       flush;
    logic [3:0] cmd;
    logic       cmd_active;
    logic [3:0] level;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] sb [$];

    always #5 clk = ~clk;

    cmd_issue_queue #(
        .DEPTH    (8),
        .RPT_W    (3),
        .IDLE_CMD (4'b0000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_cmd     (in_cmd),
        .in_rpt     (in_rpt),
        .in_ready   (in_ready),
        .flush      (flush),
        .cmd        (cmd),
        .cmd_active (cmd_active),
        .level      (level)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s = %0h at %0t", name, act, $time);
        end
    endtask

    task automatic push_entry(input logic [3:0] c, input logic [2:0] r);
        int w = 0;
        in_valid = 1'b1;
        in_cmd   = c;
        in_rpt   = r;
        #0;
        while (!in_ready && w < 100) begin
            step();
            w++;
        end
        chk("push_accept", {7'd0, in_ready}, 8'd1);
        if (in_ready) begin
            for (int k = 0; k <= int'(r); k++) sb.push_back(c);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int w = 0;
        while ((sb.size() != 0 || cmd_active) && w < 300) begin
            step();
            w++;
        end
        chk(name, {7'd0, (sb.size() == 0 && !cmd_active)}, 8'd1);
    endtask

    // Monitor: every active cycle must match the next expected command.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (cmd_active === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL mon_unexpected cmd %0h with empty scoreboard at %0t", cmd, $time);
                end else begin
                    logic [3:0] e;
                    e = sb.pop_front();
                    if (cmd !== e) begin
                        errors++;
                        $display("FAIL mon_cmd got %0h expected %0h at %0t", cmd, e, $time);
                    end else begin
                        $display("ok   mon_cmd = %0h at %0t", cmd, $time);
                    end
                end
            end else begin
                checks++;
                if (cmd !== 4'h0 || cmd_active !== 1'b0) begin
                    errors++;
                    $display("FAIL mon_idle got cmd %0h active %0b expected 0/0 at %0t", cmd, cmd_active, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int maxl;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_cmd   = 4'h0;
        in_rpt   = 3'd0;
        flush    = 1'b0;

        #2;
        chk("rst_cmd", {4'd0, cmd}, 8'h00);
        chk("rst_active", {7'd0, cmd_active}, 8'd0);
        chk("rst_level", {4'd0, level}, 8'd0);
        chk("rst_in_ready", {7'd0, in_ready}, 8'd0);
        #10 rst_n = 1'b1;
        #1;
        chk("rel_in_ready_low", {7'd0, in_ready}, 8'd0);
        step();
        chk("rel_in_ready_high", {7'd0, in_ready}, 8'd1);

        // Single entry: two-cycle latency, one cycle of hold.
        push_entry(4'h1, 3'd0);
        chk("t1_lat_cmd", {4'd0, cmd}, 8'h00);
        step();
        chk("t1_cmd", {4'd0, cmd}, 8'h01);
        chk("t1_active", {7'd0, cmd_active}, 8'd1);
        step();
        chk("t1_idle_cmd", {4'd0, cmd}, 8'h00);
        chk("t1_idle_active", {7'd0, cmd_active}, 8'd0);

        // Back-to-back without an idle gap.
        push_entry(4'h3, 3'd2);
        push_entry(4'hC, 3'd0);
        chk("t2_c0", {4'd0, cmd}, 8'h03);
        step();
        chk("t2_c1", {4'd0, cmd}, 8'h03);
        step();
        chk("t2_c2", {4'd0, cmd}, 8'h03);
        step();
        chk("t2_c3_nogap", {4'd0, cmd}, 8'h0C);
        step();
        chk("t2_idle", {3'd0, cmd_active, cmd}, 8'h00);

        // Fill to full while the head is held; 9th offer stalls.
        push_entry(4'hA, 3'd7);
        for (int i = 1; i <= 8; i++) push_entry(4'(i), 3'd7);
        chk("t3_level_full", {4'd0, level}, 8'd8);
        chk("t3_in_ready_full", {7'd0, in_ready}, 8'd0);
        push_entry(4'h9, 3'd1);
        chk("t3_level_after9", {4'd0, level}, 8'd8);
        wait_drain("t3_drain");

        // Flush mid-hold with level 5 and a same-cycle offer.
        push_entry(4'hB, 3'd7);
        for (int i = 0; i < 5; i++) push_entry(4'(4'h4 + i), 3'd7);
        chk("t4_level5", {4'd0, level}, 8'd5);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_cmd   = 4'hE;
        in_rpt   = 3'd0;
        #1;
        chk("t4_in_ready_flush", {7'd0, in_ready}, 8'd0);
        step();
        sb.delete();
        chk("t4_cmd", {4'd0, cmd}, 8'h00);
        chk("t4_active", {7'd0, cmd_active}, 8'd0);
        chk("t4_level", {4'd0, level}, 8'd0);
        step();
        chk("t4_hold_level", {4'd0, level}, 8'd0);
        step();
        chk("t4_hold_level2", {4'd0, level}, 8'd0);
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        chk("t4_post_ready", {7'd0, in_ready}, 8'd1);
        chk("t4_post_level", {4'd0, level}, 8'd0);

        // Asynchronous reset during a hold of 4'hF.
        push_entry(4'hF, 3'd7);
        push_entry(4'h6, 3'd0);
        push_entry(4'h7, 3'd0);
        chk("t5_pre_cmd", {4'd0, cmd}, 8'h0F);
        chk("t5_pre_level", {4'd0, level}, 8'd2);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        chk("t5_rst_cmd", {4'd0, cmd}, 8'h00);
        chk("t5_rst_active", {7'd0, cmd_active}, 8'd0);
        chk("t5_rst_level", {4'd0, level}, 8'd0);
        chk("t5_rst_ready", {7'd0, in_ready}, 8'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("t5_rel_ready_low", {7'd0, in_ready}, 8'd0);
        step();
        chk("t5_rel_ready_high", {7'd0, in_ready}, 8'd1);
        for (int i = 0; i < 6; i++) step();
        chk("t5_no_old_active", {7'd0, cmd_active}, 8'd0);
        chk("t5_no_old_level", {4'd0, level}, 8'd0);

        // Pointer wrap: 20 single-cycle entries streamed one per cycle.
        maxl = 0;
        for (int i = 0; i < 20; i++) begin
            push_entry(4'(i), 3'd0);
            if (int'(level) > maxl) maxl = int'(level);
        end
        wait_drain("t6_drain");
        chk("t6_max_level_le2", {7'd0, (maxl <= 2)}, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
